// File: rtl/fifo_wr_arbiter.sv
// Two-requester burst write arbiter in front of a FIFO write port.
// Round-robin on ties; grants fixed-length bursts and stalls on full or reset-busy.
module fifo_wr_arbiter #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_BURST_LEN  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic                    req1,
    output logic                    gnt0,
    output logic                    gnt1,
    input  logic                    s0_valid,
    input  logic [P_DATA_WIDTH-1:0] s0_data,
    output logic                    s0_ready,
    input  logic                    s1_valid,
    input  logic [P_DATA_WIDTH-1:0] s1_data,
    output logic                    s1_ready,
    input  logic                    fifo_full,
    input  logic                    fifo_wr_rst_busy,
    output logic                    fifo_wr_en,
    output logic [P_DATA_WIDTH-1:0] fifo_din,
    output logic                    burst_done,
    output logic                    burst_owner
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(P_BURST_LEN - 1);

    state_t      state_q, state_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic [15:0] cnt_q, cnt_d;
    logic        burst_done_q, burst_done_d;
    logic        burst_owner_q, burst_owner_d;
    logic        last_q, last_d;
    logic        pick;

    always_comb begin
        state_d       = state_q;
        gnt0_d        = gnt0_q;
        gnt1_d        = gnt1_q;
        cnt_d         = cnt_q;
        burst_done_d  = 1'b0;
        burst_owner_d = burst_owner_q;
        last_d        = last_q;
        pick          = 1'b0;

        s0_ready   = gnt0_q & ~fifo_full & ~fifo_wr_rst_busy;
        s1_ready   = gnt1_q & ~fifo_full & ~fifo_wr_rst_busy;
        fifo_wr_en = (s0_valid & s0_ready) | (s1_valid & s1_ready);
        fifo_din   = gnt1_q ? s1_data : s0_data;

        case (state_q)
            IDLE: begin
                // Holding off while burst_done is high guarantees one idle cycle between bursts.
                if (!fifo_wr_rst_busy && !burst_done_q && (req0 || req1)) begin
                    pick    = (req0 && req1) ? ~last_q : req1;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (fifo_wr_en) begin
                    if (cnt_q == LAST_CNT) begin
                        gnt0_d        = 1'b0;
                        gnt1_d        = 1'b0;
                        cnt_d         = 16'd0;
                        last_d        = gnt1_q;
                        burst_done_d  = 1'b1;
                        burst_owner_d = gnt1_q;
                        state_d       = IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Last-served resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            cnt_q         <= 16'd0;
            burst_done_q  <= 1'b0;
            burst_owner_q <= 1'b0;
            last_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            cnt_q         <= cnt_d;
            burst_done_q  <= burst_done_d;
            burst_owner_q <= burst_owner_d;
            last_q        <= last_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign burst_done  = burst_done_q;
    assign burst_owner = burst_owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with 4-word bursts.
// A negedge monitor logs FIFO writes and burst completions for the scenario checks.
module tb_fifo_wr_arbiter;

    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          gnt0, gnt1;
    logic          s0_valid = 1'b0, s1_valid = 1'b0;
    logic [DW-1:0] s0_data = 32'd1, s1_data = 32'h101;
    logic          s0_ready, s1_ready;
    logic          fifo_full = 1'b0, fifo_wr_rst_busy = 1'b0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic          burst_done, burst_owner;

    int checkCount = 0;
    int passCount = 0;

    logic [DW-1:0] wrLog[$];
    logic          doneLog[$];
    int            lenLog[$];
    int            curCnt = 0;
    int            bothCnt = 0;

    fifo_wr_arbiter #(.P_DATA_WIDTH(DW), .P_BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .fifo_full(fifo_full), .fifo_wr_rst_busy(fifo_wr_rst_busy),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .burst_done(burst_done), .burst_owner(burst_owner)
    );

    always #5 clk = ~clk;

    // Monitor: log accepted words, completions and burst lengths; clears while in reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            wrLog.delete();
            doneLog.delete();
            lenLog.delete();
            curCnt = 0;
            bothCnt = 0;
        end else begin
            if (gnt0 && gnt1) bothCnt++;
            if (fifo_wr_en) begin
                wrLog.push_back(fifo_din);
                curCnt++;
            end
            if (burst_done) begin
                doneLog.push_back(burst_owner);
                lenLog.push_back(curCnt);
                curCnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock cycle; a requester's data advances to its next word after each accepted write.
    task automatic applyStimulus();
        logic a0, a1;
        @(negedge clk);
        a0 = s0_valid & s0_ready;
        a1 = s1_valid & s1_ready;
        @(posedge clk);
        #1;
        if (a0) s0_data = s0_data + 32'd1;
        if (a1) s1_data = s1_data + 32'd1;
        #1;
    endtask

    task automatic clearInputs();
        req0 = 1'b0; req1 = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        fifo_full = 1'b0; fifo_wr_rst_busy = 1'b0;
        s0_data = 32'd1; s1_data = 32'h101;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearInputs();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic waitBurstDone(input int target, input int maxCycles);
        int n = 0;
        while (doneLog.size() < target && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkOutput("done_count", doneLog.size(), target);
    endtask

    initial begin
        // Reset values and a single-requester burst, including the idle dwell after completion.
        #2;
        rst_n = 1'b0;
        clearInputs();
        #1;
        checkOutput("rst_gnt0", gnt0, 1'b0);
        checkOutput("rst_gnt1", gnt1, 1'b0);
        checkOutput("rst_wr_en", fifo_wr_en, 1'b0);
        checkOutput("rst_s0_ready", s0_ready, 1'b0);
        checkOutput("rst_done", burst_done, 1'b0);
        checkOutput("rst_owner", burst_owner, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        req0 = 1'b1; s0_valid = 1'b1;
        #1;
        checkOutput("t1_no_gnt_yet", gnt0, 1'b0);
        applyStimulus();
        checkOutput("t1_gnt0", gnt0, 1'b1);
        checkOutput("t1_gnt1", gnt1, 1'b0);
        for (int k = 1; k <= BL; k++) begin
            checkOutput("t1_wr_en", fifo_wr_en, 1'b1);
            checkOutput("t1_din", fifo_din, 32'(k));
            applyStimulus();
        end
        checkOutput("t1_done", burst_done, 1'b1);
        checkOutput("t1_owner", burst_owner, 1'b0);
        checkOutput("t1_gnt0_clr", gnt0, 1'b0);
        checkOutput("t1_wr_en_off", fifo_wr_en, 1'b0);
        applyStimulus();
        checkOutput("t1_dwell_gnt0", gnt0, 1'b0);
        checkOutput("t1_done_pulse", burst_done, 1'b0);
        checkOutput("t1_owner_hold", burst_owner, 1'b0);
        applyStimulus();
        checkOutput("t1_regrant", gnt0, 1'b1);

        // Round-robin with both requesters held: order 0,1,0 of four words each.
        applyReset();
        req0 = 1'b1; req1 = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1;
        waitBurstDone(3, 60);
        req0 = 1'b0; req1 = 1'b0;
        checkOutput("t2_order0", doneLog[0], 1'b0);
        checkOutput("t2_order1", doneLog[1], 1'b1);
        checkOutput("t2_order2", doneLog[2], 1'b0);
        for (int b = 0; b < 3; b++) checkOutput("t2_len", lenLog[b], BL);
        checkOutput("t2_total", wrLog.size(), 3 * BL);
        for (int i = 0; i < 3 * BL; i++) begin
            logic [31:0] expWord;
            expWord = (i / BL == 1) ? 32'h101 + 32'(i % BL) : 32'(1 + (i / BL / 2) * BL + i % BL);
            checkOutput("t2_word", wrLog[i], expWord);
        end
        checkOutput("t2_both_gnt", bothCnt, 0);

        // FIFO full for five cycles after the second word.
        applyReset();
        req0 = 1'b1; s0_valid = 1'b1;
        applyStimulus();
        checkOutput("t3_din1", fifo_din, 32'd1);
        applyStimulus();
        checkOutput("t3_din2", fifo_din, 32'd2);
        applyStimulus();
        fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("t3_stall_wr_en", fifo_wr_en, 1'b0);
            checkOutput("t3_stall_ready", s0_ready, 1'b0);
            applyStimulus();
        end
        fifo_full = 1'b0;
        #1;
        checkOutput("t3_din3", fifo_din, 32'd3);
        checkOutput("t3_wr_en3", fifo_wr_en, 1'b1);
        applyStimulus();
        checkOutput("t3_din4", fifo_din, 32'd4);
        req0 = 1'b0;
        applyStimulus();
        checkOutput("t3_done", burst_done, 1'b1);
        checkOutput("t3_total", wrLog.size(), BL);

        // Write-side reset busy at reset release blocks the grant for ten cycles.
        rst_n = 1'b0;
        clearInputs();
        fifo_wr_rst_busy = 1'b1;
        req1 = 1'b1; s1_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            checkOutput("t4_busy_gnt1", gnt1, 1'b0);
            checkOutput("t4_busy_gnt0", gnt0, 1'b0);
        end
        fifo_wr_rst_busy = 1'b0;
        applyStimulus();
        checkOutput("t4_gnt1", gnt1, 1'b1);
        checkOutput("t4_s1_ready", s1_ready, 1'b1);
        checkOutput("t4_din", fifo_din, 32'h101);

        // Reset mid-burst abandons it silently; the next request gets a full burst.
        applyReset();
        req0 = 1'b1; s0_valid = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("t5_pre_writes", wrLog.size(), 2);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_gnt0", gnt0, 1'b0);
        checkOutput("t5_wr_en", fifo_wr_en, 1'b0);
        checkOutput("t5_s0_ready", s0_ready, 1'b0);
        checkOutput("t5_done", burst_done, 1'b0);
        @(negedge clk);
        #2;
        s0_data = 32'd1;
        rst_n = 1'b1;
        waitBurstDone(1, 20);
        req0 = 1'b0;
        checkOutput("t5_len", lenLog[0], BL);
        checkOutput("t5_total", wrLog.size(), BL);
        checkOutput("t5_owner", doneLog[0], 1'b0);

        // Owner drops its request after the first word; the burst still runs to completion.
        applyReset();
        req0 = 1'b1; s0_valid = 1'b1;
        applyStimulus();
        applyStimulus();
        req0 = 1'b0;
        waitBurstDone(1, 20);
        checkOutput("t6_total", wrLog.size(), BL);
        checkOutput("t6_owner", doneLog[0], 1'b0);
        checkOutput("t6_last_word", wrLog[BL-1], 32'(BL));
        applyStimulus();
        checkOutput("t6_no_regrant", gnt0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter P_DATA_WIDTH, default 32, width of requester data and FIFO write data.
REQ-002 The block SHALL have parameter P_BURST_LEN, default 16, words per granted burst, legal range 1..65535.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-004 Ports, in order, name direction width meaning:
- clk  input  1  single clock for all logic
- rst_n  input  1  asynchronous active-low reset
- req0 / req1  input  1  requester 0/1 burst request, level
- gnt0 / gnt1  output  1  requester 0/1 owns the write port, registered
- s0_valid / s1_valid  input  1  requester word valid
- s0_data / s1_data  input  P_DATA_WIDTH  requester word
- s0_ready / s1_ready  output  1  word accepted this cycle when valid&ready
- fifo_full  input  1  FIFO full flag, write clock domain
- fifo_wr_rst_busy  input  1  FIFO write-side reset busy
- fifo_wr_en  output  1  FIFO write enable
- fifo_din  output  P_DATA_WIDTH  FIFO write data
- burst_done  output  1  one-cycle pulse, burst completed
- burst_owner  output  1  requester index of the burst that just completed, valid with burst_done

Function
REQ-005 FSM states SHALL be IDLE and XFER; reset state IDLE.
REQ-006 In IDLE with fifo_wr_rst_busy=1, no grant SHALL be issued regardless of requests.
REQ-007 In IDLE with fifo_wr_rst_busy=0 and exactly one req high, that requester SHALL be granted; the grant register is set on the next clk edge and the FSM enters XFER.
REQ-008 In IDLE with both req high, the requester not served last SHALL be granted (round-robin); the last-served pointer resets to 1 so requester 0 wins the first tie.
REQ-009 In XFER, sX_ready for the granted requester SHALL be combinational: gntX & !fifo_full & !fifo_wr_rst_busy; the non-granted ready SHALL be 0.
REQ-010 fifo_wr_en SHALL equal the granted sX_valid & sX_ready, and fifo_din SHALL equal the granted sX_data, combinationally, zero added latency.
REQ-011 A 16-bit word counter SHALL increment on each fifo_wr_en and clear on burst completion.
REQ-012 A write with counter = P_BURST_LEN-1 SHALL complete the burst: on that edge the grant clears, counter clears, the last-served pointer updates, and the FSM returns to IDLE.
REQ-013 burst_done SHALL pulse high for exactly the cycle after the completing edge, and burst_owner SHALL hold the completed requester index from that cycle until the next completion.
REQ-014 A new grant SHALL NOT be issued in the cycle where burst_done is high; minimum IDLE dwell is one cycle between bursts.
REQ-015 Deassertion of req by the owner during XFER SHALL be ignored; the burst continues until P_BURST_LEN words have been written.
REQ-016 fifo_full or fifo_wr_rst_busy high during XFER SHALL stall transfer with no word lost or duplicated; the counter holds.
REQ-017 At most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-018 For P_BURST_LEN=1, each grant SHALL complete after the first accepted word.

Reset
REQ-019 On rst_n low, asynchronously: FSM=IDLE, gnt0=gnt1=0, counter=0, burst_done=0, burst_owner=0, last-served pointer=1; s0_ready=s1_ready=fifo_wr_en=0 follow from no grant.
REQ-020 Reset asserted mid-burst SHALL abandon the burst with no completion pulse; after release, arbitration restarts from REQ-008 defaults.

Verification
REQ-021 P_BURST_LEN=4, req0 only, s0_valid constant, data 1..4 -> gnt0 one cycle after req0, fifo_din 1,2,3,4 on four consecutive wr_en cycles, burst_done=1 with burst_owner=0 the cycle after the 4th write.
REQ-022 req0 and req1 both held high for 3 bursts -> grant order 0,1,0, each burst exactly 4 writes, never both grants high.
REQ-023 fifo_full high for 5 cycles after the 2nd word -> wr_en and s0_ready low for those 5 cycles, words 3,4 written afterwards, total writes = 4.
REQ-024 fifo_wr_rst_busy high at reset release for 10 cycles with req1 high -> no grant until busy falls, then gnt1 on the following edge.
REQ-025 rst_n pulsed low after 2 words of a burst -> all outputs 0 immediately, no burst_done; next request receives a full 4-word burst.
REQ-026 req0 dropped after the 1st word, s0_valid kept -> 3 further words written, burst_done still asserted.
